// File: rtl/data_bus_receive_ml_if.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_receive_ml_if
// Brief    : Bus bundle between the multi-lane data bus receiver and its
//            surroundings: lane bytes and data-mode controls in, ordered-set
//            codes and forwarded transport bytes out.
// Revision : 1.0 - initial release
// ============================================================================
interface data_bus_receive_ml_if #(
  parameter int LANES = 2
);
  logic                   data_os;
  logic [3:0]             d_sel;
  logic [8*LANES-1:0]     lanes_rx;
  logic [8*LANES-1:0]     transport_layer_data_out;
  logic [3:0]             os_in;
  logic                   os_valid;
  logic [4*LANES-1:0]     os_lane;
  logic                   lane_mismatch;

  // Side that supplies lane bytes and consumes detection results.
  modport master (
    output data_os, d_sel, lanes_rx,
    input  transport_layer_data_out, os_in, os_valid, os_lane, lane_mismatch
  );

  // Receiver side.
  modport slave (
    input  data_os, d_sel, lanes_rx,
    output transport_layer_data_out, os_in, os_valid, os_lane, lane_mismatch
  );
endinterface
`default_nettype wire

// File: rtl/data_bus_receive_ml.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_receive_ml
// Brief    : Multi-lane USB4 logical-layer data bus receiver. Every lane runs
//            its own SLOS1/SLOS2 PRBS11 checkers and Gen3/Gen4 ordered-set
//            matchers; lane 0 drives the control-FSM report with a valid
//            pulse, hold timeout and cross-lane agreement flag. In data mode
//            all lane bytes are forwarded to the transport layer.
// Revision : 1.0 - initial release
// ============================================================================
module data_bus_receive_ml #(
  parameter int          LANES       = 2,
  parameter logic [10:0] SEED        = 11'b10000000000,
  parameter int          SLOS_BITS   = 2048,
  parameter int          HOLD_CYCLES = 16
) (
  input  wire logic            fsm_clk,
  input  wire logic            rst,
  data_bus_receive_ml_if.slave bus
);

  localparam int CNT_W  = $clog2(SLOS_BITS + 1);
  localparam int HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

  localparam logic [CNT_W:0]  SLOS_LEN  = SLOS_BITS;
  localparam logic [CNT_W:0]  BYTE_BITS = 8;
  localparam logic [HOLD_W:0] HOLD_LIM  = HOLD_CYCLES;
  localparam logic [HOLD_W:0] HOLD_ONE  = 1;

  localparam logic [63:0] GEN3_TS1 = 64'h0101_0000_0000_64F2;
  localparam logic [63:0] GEN3_TS2 = 64'h0100_0000_0000_64F2;
  localparam logic [31:0] GEN4_TS1 = 32'h7E02_D0F0;
  localparam logic [31:0] GEN4_TS2 = 32'h7E04_B0F0;
  localparam logic [31:0] GEN4_TS3 = 32'h7E06_90F0;
  localparam logic [31:0] GEN4_TS4 = 32'h7E0F_0F00;

  localparam logic [3:0] CODE_SLOS1 = 4'd0;
  localparam logic [3:0] CODE_SLOS2 = 4'd1;
  localparam logic [3:0] CODE_G3TS1 = 4'd2;
  localparam logic [3:0] CODE_G3TS2 = 4'd3;
  localparam logic [3:0] CODE_G4TS1 = 4'd4;
  localparam logic [3:0] CODE_G4TS2 = 4'd5;
  localparam logic [3:0] CODE_G4TS3 = 4'd6;
  localparam logic [3:0] CODE_G4TS4 = 4'd7;
  localparam logic [3:0] CODE_DATA  = 4'd8;
  localparam logic [3:0] CODE_NONE  = 4'd9;

  typedef struct packed {
    logic             hit;
    logic [10:0]      s;
    logic [CNT_W-1:0] cnt;
  } slos_t;

  // Checks one byte MSB-first against eight PRBS11 bits starting at s.
  // Returns {all_bits_match, state_after_eight_steps}.
  function automatic logic [11:0] prbs_byte(input logic [10:0] s,
                                            input logic [7:0]  b,
                                            input logic        inv);
    logic [10:0] st;
    logic        ok;
    st = s;
    ok = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (b[i] != (st[0] ^ inv)) ok = 1'b0;
      st = {st[9:0], st[10] ^ st[8]};
    end
    return {ok, st};
  endfunction

  // Next SLOS checker state. A broken run immediately retries the same byte
  // as the start of a fresh sequence so no alignment byte is lost.
  function automatic slos_t slos_next(input logic [10:0]      s,
                                      input logic [CNT_W-1:0] cnt,
                                      input logic [7:0]       b,
                                      input logic             inv);
    logic [11:0]  run;
    logic [11:0]  fresh;
    logic [CNT_W:0] inc;
    slos_t        nx;
    run     = prbs_byte(s, b, inv);
    fresh   = prbs_byte(SEED, b, inv);
    inc     = {1'b0, cnt} + BYTE_BITS;
    nx.hit  = 1'b0;
    nx.s    = SEED;
    nx.cnt  = '0;
    if (run[11]) begin
      if (inc >= SLOS_LEN) begin
        nx.hit = 1'b1;
      end else begin
        nx.s   = run[10:0];
        nx.cnt = inc[CNT_W-1:0];
      end
    end else if (fresh[11]) begin
      nx.s   = fresh[10:0];
      nx.cnt = BYTE_BITS[CNT_W-1:0];
    end
    return nx;
  endfunction

  logic       data_mode;
  logic [3:0] lane_code [LANES];
  logic       mismatch;

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W:0]   hold_inc;

  assign data_mode = bus.data_os && (bus.d_sel == 4'h8);
  assign hold_inc  = {1'b0, hold_q} + HOLD_ONE;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0]       lane_q;
    logic [63:0]      window;
    logic [63:0]      window_nx;
    logic [10:0]      s1_q;
    logic [10:0]      s2_q;
    logic [CNT_W-1:0] c1_q;
    logic [CNT_W-1:0] c2_q;
    slos_t            s1_nx;
    slos_t            s2_nx;
    logic [3:0]       code;

    assign window_nx = {window[55:0], lane_q};
    assign s1_nx     = slos_next(s1_q, c1_q, lane_q, 1'b0);
    assign s2_nx     = slos_next(s2_q, c2_q, lane_q, 1'b1);
    assign lane_code[l] = code;

    // Same-cycle hits on this lane resolve in fixed priority order.
    always_comb begin
      code = CODE_NONE;
      if (s1_nx.hit)                    code = CODE_SLOS1;
      else if (s2_nx.hit)               code = CODE_SLOS2;
      else if (window_nx == GEN3_TS1)   code = CODE_G3TS1;
      else if (window_nx == GEN3_TS2)   code = CODE_G3TS2;
      else if (window_nx[31:0] == GEN4_TS1) code = CODE_G4TS1;
      else if (window_nx[31:0] == GEN4_TS2) code = CODE_G4TS2;
      else if (window_nx[31:0] == GEN4_TS3) code = CODE_G4TS3;
      else if (window_nx[31:0] == GEN4_TS4) code = CODE_G4TS4;
    end

    // Input byte stage and detector state; data mode restarts detection.
    always_ff @(posedge fsm_clk or negedge rst) begin
      if (!rst) begin
        lane_q <= '0;
        window <= '0;
        s1_q   <= SEED;
        s2_q   <= SEED;
        c1_q   <= '0;
        c2_q   <= '0;
      end else begin
        lane_q <= bus.lanes_rx[8*l +: 8];
        if (data_mode) begin
          window <= '0;
          s1_q   <= SEED;
          s2_q   <= SEED;
          c1_q   <= '0;
          c2_q   <= '0;
        end else begin
          window <= window_nx;
          s1_q   <= s1_nx.s;
          s2_q   <= s2_nx.s;
          c1_q   <= s1_nx.cnt;
          c2_q   <= s2_nx.cnt;
        end
      end
    end
  end

  // Any other lane that did not see lane 0's code this cycle disagrees.
  always_comb begin
    mismatch = 1'b0;
    for (int l = 1; l < LANES; l++) begin
      if (lane_code[l] != lane_code[0]) mismatch = 1'b1;
    end
  end

  // Report register: data forwarding, lane-0 report, hold timeout and
  // per-lane last-seen codes.
  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst) begin
      bus.transport_layer_data_out <= '0;
      bus.os_in                    <= CODE_NONE;
      bus.os_valid                 <= 1'b0;
      bus.os_lane                  <= {LANES{CODE_NONE}};
      bus.lane_mismatch            <= 1'b0;
      hold_q                       <= '0;
    end else if (data_mode) begin
      bus.transport_layer_data_out <= bus.lanes_rx;
      bus.os_in                    <= CODE_DATA;
      bus.os_valid                 <= 1'b0;
      bus.lane_mismatch            <= 1'b0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_code[l] != CODE_NONE) bus.os_lane[4*l +: 4] <= lane_code[l];
      end
      if (lane_code[0] != CODE_NONE) begin
        bus.os_in         <= lane_code[0];
        bus.os_valid      <= 1'b1;
        bus.lane_mismatch <= mismatch;
        hold_q            <= '0;
      end else begin
        bus.os_valid <= 1'b0;
        if (hold_inc <= HOLD_LIM) hold_q <= hold_inc[HOLD_W-1:0];
        if ((HOLD_CYCLES != 0) && (hold_inc >= HOLD_LIM)) bus.os_in <= CODE_NONE;
      end
    end
  end

endmodule
`default_nettype wire
